keypad_scan_ctrl: RTL and testbench
===================================

# keypad_scan_ctrl

Scans a ROWS×COLS passive key matrix and reports one debounced key press at a time on a valid/ready event port. It drives one column low at a time, synchronises the row inputs and debounces a candidate key with a single shared counter. Released keys are also debounced before scanning resumes. It sits between the board key-matrix pins and the front-panel/UI logic, and replaces per-input debounce instances for matrix keypads.

## Interface
- ROWS, default 4: matrix rows; range 1–8.
- COLS, default 4: matrix columns; range 1–8.
- SETTLE, default 16: cycles each column is driven before its rows are sampled; must be ≥3.
- DB_COUNT, default 255: consecutive stable cycles needed to accept a press or release; must be ≥1.
- CODE_W, default $clog2(ROWS*COLS): key code width.
- CLK  in  1  system clock; all logic on the rising edge.
- RST  in  1  synchronous, active-high reset.
- ROW_IN  in  ROWS  raw row pins, active-low (pulled up externally); asynchronous to CLK.
- COL_OUT  out  COLS  column drive, active-low; exactly one bit is low at all times.
- KEY_CODE  out  CODE_W  accepted key, encoded as col*ROWS + row; stable while KEY_VALID=1.
- KEY_VALID  out  1  press event pending.
- KEY_READY  in  1  consumer accepts the event; the transfer occurs when VALID&&READY on a rising edge.
- KEY_HELD  out  1  high from press acceptance until release acceptance.

## Operation
- ROW_IN passes through a 2-flop synchroniser. All "row" references below mean synchronised, inverted rows (1 = pressed).
- The FSM has four states: SCAN, DEBOUNCE, PRESSED, RELEASE.
- **SCAN:**
  - col_idx drives COL_OUT. settle_cnt counts 0..SETTLE-1.
  - At settle_cnt==SETTLE-1, rows are sampled.
  - If rows==0, col_idx advances, wrapping COLS-1→0.
  - If rows≠0, the lowest set row index is captured as cand_row, the counter is cleared, and the FSM goes to DEBOUNCE. col_idx is held.
- **DEBOUNCE:**
  - Each cycle, if row[cand_row]==1, db_cnt increments. Otherwise, the FSM returns to SCAN at the next column with settle_cnt=0.
  - When db_cnt==DB_COUNT-1 and row[cand_row]==1, KEY_CODE is latched to col_idx*ROWS+cand_row. KEY_VALID and KEY_HELD are set and the FSM goes to PRESSED.
  - Other rows changing is ignored.
- **PRESSED:**
  - KEY_VALID holds until the handshake, regardless of the key's state.
  - On the handshake, KEY_VALID is cleared, db_cnt is cleared, and the FSM goes to RELEASE.
- **RELEASE:**
  - Column is held. db_cnt increments while row[cand_row]==0 and clears to 0 when it is 1.
  - When db_cnt==DB_COUNT-1 and the row is 0, KEY_HELD is cleared and the FSM goes to SCAN at the next column.
- Only one key is reported at a time. Other keys pressed while one is held are not reported. Keys still down when scanning resumes are picked up again.
- db_cnt is 16 bits and saturation never occurs: it is cleared on every state entry.

## Timing
- Reset values:
  - state=SCAN, col_idx=0, settle_cnt=0, db_cnt=0.
  - COL_OUT={COLS-1{1},0} (column 0 driven).
  - KEY_VALID=0, KEY_CODE=0, KEY_HELD=0.
  - Synchroniser flops = all-ones (released).
- RST asserted in any state forces these values on the next edge, including mid-DEBOUNCE and while KEY_VALID is high. A pending event is discarded.
- Pin-to-detection delay: 2 synchroniser cycles plus the remainder of the current settle window.
- Press acceptance: KEY_VALID rises DB_COUNT cycles after DEBOUNCE entry, with no glitch.
- KEY_VALID may be high with KEY_READY already high. The transfer then takes 1 cycle: VALID is high for exactly one cycle.
- KEY_VALID never depends combinationally on KEY_READY. All outputs are registered.
- Column change and the start of a new settle window happen on the same edge. The first sample is SETTLE cycles later.

## Structure
- Package keypad_pkg holds:
  - the state enum (SCAN, DEBOUNCE, PRESSED, RELEASE);
  - the code-width function;
  - the 16-bit db_cnt width constant.
- Sub-module keypad_row_sync: ROWS-wide 2-flop synchroniser, reset to all-ones, on CLK/RST.
- The FSM, counters and output registers live in keypad_scan_ctrl.

## Test plan
All scenarios use ROWS=4, COLS=4, SETTLE=4, DB_COUNT=8.
1. **Reset and idle scan:** RST for 2 cycles, all rows high. COL_OUT cycles 1110→1101→1011→0111→1110, 4 cycles per column. KEY_VALID and KEY_HELD stay 0.
2. **Clean press:** hold row 2 low whenever column 1 is driven, with KEY_READY=1. Expect KEY_CODE=6, KEY_VALID high for 1 cycle and KEY_HELD=1. After release, KEY_HELD falls 8 cycles after the synchronised row goes high, and scanning resumes at column 2.
3. **Bounce:** toggle row 0 during column 3 every 3 cycles for 30 cycles, then hold it low. Expect no event until 8 consecutive stable cycles, then one event with KEY_CODE=12.
4. **Backpressure:** press key 5 with KEY_READY=0 for 50 cycles and release the key at cycle 20. KEY_VALID and KEY_CODE=5 must hold. Raise READY: one transfer occurs, then RELEASE completes and no duplicate event is produced.
5. **Multi-key:** rows 1 and 3 low on column 0. Expect KEY_CODE=1 only. Keep row 3 held after releasing row 1: the next event is KEY_CODE=3 after a full scan.
6. **Reset mid-operation:** assert RST during DEBOUNCE, and again while KEY_VALID=1. The next cycle must show KEY_VALID=0, KEY_HELD=0 and COL_OUT=1110.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared types and sizing helpers for the matrix keypad scanner.
package keypad_pkg;

  // Scanner FSM states.
  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    PRESSED  = 2'd2,
    RELEASE  = 2'd3
  } kp_state_e;

  // Width of the shared press/release debounce counter.
  localparam int DB_CNT_W = 16;

  // Width of a key code able to hold every col*rows+row value (never zero).
  function automatic int code_width(input int rows, input int cols);
    return (rows * cols > 1) ? $clog2(rows * cols) : 1;
  endfunction

  // Width of an index into a set of n items (never zero).
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/keypad_row_sync.sv
// Two-flop synchroniser for the asynchronous, active-low row pins.
// Resets to all-ones so no key appears pressed out of reset.
module keypad_row_sync #(
  parameter int ROWS = 4
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic [ROWS-1:0] row_async,
  output logic [ROWS-1:0] row_sync
);

  generate
    for (genvar gi = 0; gi < ROWS; gi++) begin : g_bit
      logic meta_reg;
      logic sync_reg;

      // Per-row two-stage capture of the raw pin.
      always_ff @(posedge CLK) begin
        if (RST) begin
          meta_reg <= 1'b1;
          sync_reg <= 1'b1;
        end else begin
          meta_reg <= row_async[gi];
          sync_reg <= meta_reg;
        end
      end

      assign row_sync[gi] = sync_reg;
    end
  endgenerate

endmodule

// File: rtl/keypad_scan_ctrl.sv
// Matrix keypad scanner: drives one column low at a time, debounces a single
// candidate key with a shared counter, reports it on a valid/ready port and
// debounces its release before scanning resumes.
module keypad_scan_ctrl
  import keypad_pkg::*;
#(
  parameter int ROWS     = 4,
  parameter int COLS     = 4,
  parameter int SETTLE   = 16,
  parameter int DB_COUNT = 255,
  parameter int CODE_W   = code_width(ROWS, COLS)
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [ROWS-1:0]   ROW_IN,
  output logic [COLS-1:0]   COL_OUT,
  output logic [CODE_W-1:0] KEY_CODE,
  output logic              KEY_VALID,
  input  logic              KEY_READY,
  output logic              KEY_HELD
);

  localparam int ROW_W = idx_width(ROWS);
  localparam int COL_W = idx_width(COLS);
  localparam int SET_W = idx_width(SETTLE);

  localparam logic [SET_W-1:0]    SETTLE_LAST = SET_W'(SETTLE - 1);
  localparam logic [DB_CNT_W-1:0] DB_LAST     = DB_CNT_W'(DB_COUNT - 1);
  localparam logic [COL_W-1:0]    COL_LAST    = COL_W'(COLS - 1);

  logic [ROWS-1:0]     row_sync;
  logic [ROWS-1:0]     rows;          // 1 = pressed
  logic [ROW_W-1:0]    low_row;
  logic                cand_pressed;
  logic [COL_W-1:0]    col_inc;

  kp_state_e           state_reg, state_next;
  logic [COL_W-1:0]    col_idx_reg, col_idx_next;
  logic [SET_W-1:0]    settle_cnt_reg, settle_cnt_next;
  logic [DB_CNT_W-1:0] db_cnt_reg, db_cnt_next;
  logic [ROW_W-1:0]    cand_row_reg, cand_row_next;
  logic [COLS-1:0]     col_out_reg, col_out_next;
  logic [CODE_W-1:0]   key_code_reg, key_code_next;
  logic                key_valid_reg, key_valid_next;
  logic                key_held_reg, key_held_next;

  keypad_row_sync #(
    .ROWS(ROWS)
  ) u_row_sync (
    .CLK       (CLK),
    .RST       (RST),
    .row_async (ROW_IN),
    .row_sync  (row_sync)
  );

  assign rows         = ~row_sync;
  assign cand_pressed = rows[cand_row_reg];
  assign col_inc      = (col_idx_reg == COL_LAST) ? '0 : col_idx_reg + 1'b1;

  // Priority encoder: lowest pressed row on the driven column.
  always_comb begin
    low_row = '0;
    for (int i = ROWS - 1; i >= 0; i--) begin
      if (rows[i]) low_row = ROW_W'(i);
    end
  end

  // Column drive is registered from the next column index so it changes on
  // the same edge that starts the new settle window.
  generate
    for (genvar gi = 0; gi < COLS; gi++) begin : g_col
      assign col_out_next[gi] = (col_idx_next != COL_W'(gi));
    end
  endgenerate

  // Next-state, counter and output-register logic.
  always_comb begin
    state_next      = state_reg;
    col_idx_next    = col_idx_reg;
    settle_cnt_next = settle_cnt_reg;
    db_cnt_next     = db_cnt_reg;
    cand_row_next   = cand_row_reg;
    key_code_next   = key_code_reg;
    key_valid_next  = key_valid_reg;
    key_held_next   = key_held_reg;

    unique case (state_reg)
      SCAN: begin
        if (settle_cnt_reg == SETTLE_LAST) begin
          settle_cnt_next = '0;
          if (rows == '0) begin
            col_idx_next = col_inc;
          end else begin
            cand_row_next = low_row;
            db_cnt_next   = '0;
            state_next    = DEBOUNCE;
          end
        end else begin
          settle_cnt_next = settle_cnt_reg + 1'b1;
        end
      end

      DEBOUNCE: begin
        if (cand_pressed) begin
          if (db_cnt_reg == DB_LAST) begin
            key_code_next  = CODE_W'(int'(col_idx_reg) * ROWS + int'(cand_row_reg));
            key_valid_next = 1'b1;
            key_held_next  = 1'b1;
            db_cnt_next    = '0;
            state_next     = PRESSED;
          end else begin
            db_cnt_next = db_cnt_reg + 1'b1;
          end
        end else begin
          // Candidate dropped out: give up and move on to the next column.
          col_idx_next    = col_inc;
          settle_cnt_next = '0;
          db_cnt_next     = '0;
          state_next      = SCAN;
        end
      end

      PRESSED: begin
        if (key_valid_reg && KEY_READY) begin
          key_valid_next = 1'b0;
          db_cnt_next    = '0;
          state_next     = RELEASE;
        end
      end

      RELEASE: begin
        if (cand_pressed) begin
          db_cnt_next = '0;
        end else if (db_cnt_reg == DB_LAST) begin
          key_held_next   = 1'b0;
          col_idx_next    = col_inc;
          settle_cnt_next = '0;
          db_cnt_next     = '0;
          state_next      = SCAN;
        end else begin
          db_cnt_next = db_cnt_reg + 1'b1;
        end
      end

      default: state_next = SCAN;
    endcase
  end

  // State and output registers; reset discards any pending event.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg      <= SCAN;
      col_idx_reg    <= '0;
      settle_cnt_reg <= '0;
      db_cnt_reg     <= '0;
      cand_row_reg   <= '0;
      col_out_reg    <= ~COLS'(1);
      key_code_reg   <= '0;
      key_valid_reg  <= 1'b0;
      key_held_reg   <= 1'b0;
    end else begin
      state_reg      <= state_next;
      col_idx_reg    <= col_idx_next;
      settle_cnt_reg <= settle_cnt_next;
      db_cnt_reg     <= db_cnt_next;
      cand_row_reg   <= cand_row_next;
      col_out_reg    <= col_out_next;
      key_code_reg   <= key_code_next;
      key_valid_reg  <= key_valid_next;
      key_held_reg   <= key_held_next;
    end
  end

  assign COL_OUT   = col_out_reg;
  assign KEY_CODE  = key_code_reg;
  assign KEY_VALID = key_valid_reg;
  assign KEY_HELD  = key_held_reg;

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Bench for keypad_scan_ctrl: a key-matrix model drives ROW_IN from COL_OUT
// and a set of pressed keys; expected codes and latencies come from the
// matrix geometry and the debounce/settle parameters.
module tb_keypad_scan_ctrl;

  localparam int ROWS     = 4;
  localparam int COLS     = 4;
  localparam int SETTLE   = 4;
  localparam int DB_COUNT = 8;
  localparam int CODE_W   = 4;
  localparam int LIMIT    = 200;

  logic              CLK = 1'b0;
  logic              RST = 1'b1;
  logic [ROWS-1:0]   ROW_IN;
  logic [COLS-1:0]   COL_OUT;
  logic [CODE_W-1:0] KEY_CODE;
  logic              KEY_VALID;
  logic              KEY_READY = 1'b0;
  logic              KEY_HELD;

  bit key_mat [COLS][ROWS];
  int n_vec = 0;
  int n_err = 0;
  int xfer_q[$];
  int valid_cycles = 0;

  keypad_scan_ctrl #(
    .ROWS     (ROWS),
    .COLS     (COLS),
    .SETTLE   (SETTLE),
    .DB_COUNT (DB_COUNT),
    .CODE_W   (CODE_W)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .ROW_IN    (ROW_IN),
    .COL_OUT   (COL_OUT),
    .KEY_CODE  (KEY_CODE),
    .KEY_VALID (KEY_VALID),
    .KEY_READY (KEY_READY),
    .KEY_HELD  (KEY_HELD)
  );

  always #5 CLK = ~CLK;

  // Passive matrix: a pressed key pulls its row low while its column is driven.
  always_comb begin
    ROW_IN = '1;
    for (int c = 0; c < COLS; c++)
      for (int r = 0; r < ROWS; r++)
        if (!COL_OUT[c] && key_mat[c][r]) ROW_IN[r] = 1'b0;
  end

  // Transaction log: one line per accepted event.
  always @(negedge CLK) begin
    #2;
    if (!RST && KEY_VALID) valid_cycles++;
    if (!RST && KEY_VALID && KEY_READY) begin
      xfer_q.push_back(int'(KEY_CODE));
      $display("[%0t] transfer code=%0d", $time, KEY_CODE);
    end
  end

  function automatic logic [COLS-1:0] col_pat(input int c);
    logic [COLS-1:0] p;
    p = '1;
    p[c] = 1'b0;
    return p;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic clear_keys();
    for (int c = 0; c < COLS; c++)
      for (int r = 0; r < ROWS; r++) key_mat[c][r] = 1'b0;
  endtask

  task automatic wait_valid(input int limit, output int cnt);
    cnt = 0;
    while (!KEY_VALID && cnt < limit) begin
      @(negedge CLK);
      cnt++;
    end
  endtask

  task automatic wait_held_low(input int limit, output int cnt);
    cnt = 0;
    while (KEY_HELD && cnt < limit) begin
      @(negedge CLK);
      cnt++;
    end
  endtask

  task automatic test_reset();
    int bad_col, bad_out;
    RST = 1'b1;
    KEY_READY = 1'b0;
    clear_keys();
    tick(2);
    n_vec++;
    if (COL_OUT !== 4'b1110) begin
      n_err++; $display("FAIL reset_col_out got=%b exp=1110", COL_OUT);
    end
    n_vec++;
    if ({KEY_VALID, KEY_HELD, KEY_CODE} !== '0) begin
      n_err++; $display("FAIL reset_outputs got valid=%b held=%b code=%0d exp 0/0/0",
                        KEY_VALID, KEY_HELD, KEY_CODE);
    end
    RST = 1'b0;
    bad_col = 0;
    bad_out = 0;
    for (int k = 1; k <= 5 * SETTLE; k++) begin
      @(negedge CLK);
      if (COL_OUT !== col_pat((k / SETTLE) % COLS)) begin
        bad_col++;
        $display("FAIL idle_scan cycle=%0d got=%b exp=%b", k, COL_OUT, col_pat((k / SETTLE) % COLS));
      end
      if (KEY_VALID !== 1'b0 || KEY_HELD !== 1'b0) bad_out++;
      n_vec++;
    end
    n_err += bad_col;
    n_vec++;
    if (bad_out != 0) begin
      n_err++; $display("FAIL idle_outputs got=%0d active cycles exp=0", bad_out);
    end
  endtask

  // One press/transfer/release of key (c,r) with READY raised after ready_delay.
  task automatic press_cycle(input string name, input int c, input int r, input int ready_delay);
    int base, vc0, cnt;
    base = xfer_q.size();
    vc0 = valid_cycles;
    KEY_READY = (ready_delay == 0);
    key_mat[c][r] = 1'b1;
    wait_valid(LIMIT, cnt);
    n_vec++;
    if (KEY_VALID !== 1'b1 || KEY_CODE !== CODE_W'(c * ROWS + r) || KEY_HELD !== 1'b1) begin
      n_err++; $display("FAIL %s_accept got valid=%b code=%0d held=%b exp 1/%0d/1",
                        name, KEY_VALID, KEY_CODE, KEY_HELD, c * ROWS + r);
    end
    if (ready_delay > 0) begin
      tick(ready_delay);
      KEY_READY = 1'b1;
    end
    tick(3);
    n_vec++;
    if (xfer_q.size() != base + 1 || xfer_q[base] != c * ROWS + r) begin
      n_err++; $display("FAIL %s_transfer got count=%0d exp count=1 code=%0d",
                        name, xfer_q.size() - base, c * ROWS + r);
    end
    n_vec++;
    if (valid_cycles - vc0 != ready_delay + 1 || KEY_VALID !== 1'b0) begin
      n_err++; $display("FAIL %s_valid_width got=%0d exp=%0d", name, valid_cycles - vc0, ready_delay + 1);
    end
    key_mat[c][r] = 1'b0;
    wait_held_low(LIMIT, cnt);
    n_vec++;
    if (KEY_HELD !== 1'b0 || cnt != 2 + DB_COUNT) begin
      n_err++; $display("FAIL %s_release_latency got=%0d exp=%0d", name, cnt, 2 + DB_COUNT);
    end
    n_vec++;
    if (COL_OUT !== col_pat((c + 1) % COLS)) begin
      n_err++; $display("FAIL %s_resume_col got=%b exp=%b", name, COL_OUT, col_pat((c + 1) % COLS));
    end
  endtask

  task automatic test_clean_press();
    press_cycle("clean", 1, 2, 0);
  endtask

  task automatic test_bounce();
    int base, vc0, cnt, p;
    bit lvl;
    KEY_READY = 1'b1;
    base = xfer_q.size();
    vc0 = valid_cycles;
    p = int'($urandom_range(1, 4));
    lvl = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (i % p == 0) lvl = ~lvl;
      key_mat[3][0] = lvl;
      @(negedge CLK);
    end
    key_mat[3][0] = 1'b0;
    tick(1);
    n_vec++;
    if (valid_cycles != vc0) begin
      n_err++; $display("FAIL bounce_no_event got=%0d valid cycles exp=0 (period %0d)", valid_cycles - vc0, p);
    end
    key_mat[3][0] = 1'b1;
    wait_valid(LIMIT, cnt);
    n_vec++;
    if (KEY_VALID !== 1'b1 || KEY_CODE !== 4'd12) begin
      n_err++; $display("FAIL bounce_accept got valid=%b code=%0d exp 1/12", KEY_VALID, KEY_CODE);
    end
    n_vec++;
    if (cnt < 2 + DB_COUNT) begin
      n_err++; $display("FAIL bounce_latency got=%0d exp>=%0d", cnt, 2 + DB_COUNT);
    end
    tick(3);
    key_mat[3][0] = 1'b0;
    wait_held_low(LIMIT, cnt);
    tick(20);
    n_vec++;
    if (xfer_q.size() != base + 1 || xfer_q[base] != 12 || KEY_HELD !== 1'b0) begin
      n_err++; $display("FAIL bounce_single_event got count=%0d held=%b exp count=1 code=12 held=0",
                        xfer_q.size() - base, KEY_HELD);
    end
  endtask

  task automatic test_backpressure();
    int base, vc0, cnt, bad;
    KEY_READY = 1'b0;
    base = xfer_q.size();
    key_mat[1][1] = 1'b1;
    wait_valid(LIMIT, cnt);
    n_vec++;
    if (KEY_VALID !== 1'b1 || KEY_CODE !== 4'd5) begin
      n_err++; $display("FAIL bp_accept got valid=%b code=%0d exp 1/5", KEY_VALID, KEY_CODE);
    end
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      if (i == 20) key_mat[1][1] = 1'b0;
      @(negedge CLK);
      if (KEY_VALID !== 1'b1 || KEY_CODE !== 4'd5 || KEY_HELD !== 1'b1) bad++;
    end
    n_vec++;
    if (bad != 0 || xfer_q.size() != base) begin
      n_err++; $display("FAIL bp_hold got=%0d bad cycles, %0d transfers exp 0/0", bad, xfer_q.size() - base);
    end
    KEY_READY = 1'b1;
    tick(3);
    n_vec++;
    if (xfer_q.size() != base + 1 || xfer_q[base] != 5 || KEY_VALID !== 1'b0) begin
      n_err++; $display("FAIL bp_transfer got count=%0d valid=%b exp count=1 code=5 valid=0",
                        xfer_q.size() - base, KEY_VALID);
    end
    wait_held_low(LIMIT, cnt);
    vc0 = valid_cycles;
    tick(80);
    n_vec++;
    if (KEY_HELD !== 1'b0 || valid_cycles != vc0 || xfer_q.size() != base + 1) begin
      n_err++; $display("FAIL bp_no_duplicate got held=%b extra valid=%0d count=%0d exp 0/0/1",
                        KEY_HELD, valid_cycles - vc0, xfer_q.size() - base);
    end
  endtask

  task automatic test_multi_key();
    int base, cnt;
    KEY_READY = 1'b1;
    base = xfer_q.size();
    key_mat[0][1] = 1'b1;
    key_mat[0][3] = 1'b1;
    wait_valid(LIMIT, cnt);
    n_vec++;
    if (KEY_VALID !== 1'b1 || KEY_CODE !== 4'd1) begin
      n_err++; $display("FAIL multi_first got valid=%b code=%0d exp 1/1", KEY_VALID, KEY_CODE);
    end
    tick(3);
    key_mat[0][1] = 1'b0;
    wait_held_low(LIMIT, cnt);
    n_vec++;
    if (KEY_HELD !== 1'b0 || COL_OUT !== col_pat(1)) begin
      n_err++; $display("FAIL multi_release got held=%b col=%b exp 0/%b", KEY_HELD, COL_OUT, col_pat(1));
    end
    wait_valid(LIMIT, cnt);
    n_vec++;
    if (KEY_VALID !== 1'b1 || KEY_CODE !== 4'd3 || cnt < (COLS - 1) * SETTLE) begin
      n_err++; $display("FAIL multi_second got valid=%b code=%0d after %0d cycles exp 1/3 after>=%0d",
                        KEY_VALID, KEY_CODE, cnt, (COLS - 1) * SETTLE);
    end
    tick(3);
    key_mat[0][3] = 1'b0;
    wait_held_low(LIMIT, cnt);
    n_vec++;
    if (xfer_q.size() != base + 2 || xfer_q[base] != 1 || xfer_q[base + 1] != 3) begin
      n_err++; $display("FAIL multi_sequence got count=%0d exp codes 1,3", xfer_q.size() - base);
    end
  endtask

  task automatic test_random();
    int c, r, d;
    for (int it = 0; it < 10; it++) begin
      c = int'($urandom_range(0, COLS - 1));
      r = int'($urandom_range(0, ROWS - 1));
      d = int'($urandom_range(0, 4));
      press_cycle("random", c, r, d);
      tick(int'($urandom_range(0, 7)));
    end
  endtask

  task automatic test_reset_mid();
    int base, vc0, cnt;
    KEY_READY = 1'b0;
    RST = 1'b1;
    clear_keys();
    tick(2);
    RST = 1'b0;
    key_mat[0][2] = 1'b1;
    tick(7);
    RST = 1'b1;
    tick(1);
    n_vec++;
    if (KEY_VALID !== 1'b0 || KEY_HELD !== 1'b0 || COL_OUT !== 4'b1110) begin
      n_err++; $display("FAIL rst_debounce got valid=%b held=%b col=%b exp 0/0/1110", KEY_VALID, KEY_HELD, COL_OUT);
    end
    RST = 1'b0;
    wait_valid(LIMIT, cnt);
    n_vec++;
    if (KEY_VALID !== 1'b1 || KEY_CODE !== 4'd2 || cnt != SETTLE + DB_COUNT) begin
      n_err++; $display("FAIL rst_redetect got valid=%b code=%0d after %0d exp 1/2 after %0d",
                        KEY_VALID, KEY_CODE, cnt, SETTLE + DB_COUNT);
    end
    base = xfer_q.size();
    RST = 1'b1;
    clear_keys();
    tick(1);
    n_vec++;
    if (KEY_VALID !== 1'b0 || KEY_HELD !== 1'b0 || COL_OUT !== 4'b1110 || KEY_CODE !== '0) begin
      n_err++; $display("FAIL rst_pending got valid=%b held=%b col=%b code=%0d exp 0/0/1110/0",
                        KEY_VALID, KEY_HELD, COL_OUT, KEY_CODE);
    end
    RST = 1'b0;
    KEY_READY = 1'b1;
    tick(1);
    vc0 = valid_cycles;
    tick(40);
    n_vec++;
    if (valid_cycles != vc0 || xfer_q.size() != base) begin
      n_err++; $display("FAIL rst_discard got valid cycles=%0d transfers=%0d exp 0/0",
                        valid_cycles - vc0, xfer_q.size() - base);
    end
  endtask

  initial begin
    clear_keys();
    test_reset();
    test_clean_press();
    test_bounce();
    test_backpressure();
    test_multi_key();
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
